// File: rtl/mem_cycle_gen.sv
// mem_cycle_gen
// Memory-cycle sequencer. Each accepted request runs a complete read or write
// of one DATA_WIDTH word over a BUS_WIDTH multiplexed data bus. The word is
// transferred one byte lane per sub-cycle, starting with the least-significant
// lane. Each lane has the form ADDR -> STROBE (wait states, ready extension and
// timeout) -> HOLD. The cycle ends with a one-clock DONE.
//
// Bit numbering: the word is TI-numbered, so TI bit 0 is the MSB. The vectors
// are declared descending, so TI bit i is vector bit DATA_WIDTH-1-i. Lane L
// covers TI bits [L*BUS_WIDTH : L*BUS_WIDTH+BUS_WIDTH-1]. That is vector bits
// [(LANES-1-L)*BUS_WIDTH +: BUS_WIDTH], so lane LANES-1 is the least-significant
// byte.
//
// Ports:
//   clk        system clock; all logic on the rising edge
//   reset_n    synchronous active-low reset
//   request    start a cycle (sampled only when idle)
//   rnw        1 = read, 0 = write (latched at acceptance)
//   data_word  write data (latched at acceptance)
//   ready      external ready; low stretches the strobe
//   bus_in     read data from the bus
//   bus_out    write data to the bus
//   bus_oe     drive enable for bus_out
//   memen_n    memory enable, active low
//   we_n       write strobe, active low
//   dbin       read direction/strobe, active high
//   byte_sel   current lane index
//   rdata      assembled read word
//   busy       high from acceptance through DONE
//   done       one-clock completion pulse
//   error      strobe timeout flag, valid with done
module mem_cycle_gen #(
    parameter int DATA_WIDTH  = 16,
    parameter int BUS_WIDTH   = 8,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 64,
    localparam int LANES      = DATA_WIDTH / BUS_WIDTH,
    localparam int SELW       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  request,
    input  logic                  rnw,
    input  logic [DATA_WIDTH-1:0] data_word,
    input  logic                  ready,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    output logic [BUS_WIDTH-1:0]  bus_out,
    output logic                  bus_oe,
    output logic                  memen_n,
    output logic                  we_n,
    output logic                  dbin,
    output logic [SELW-1:0]       byte_sel,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int IDXW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW:0]   WS_MIN  = (CNTW + 1)'(WAIT_STATES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [SELW-1:0]       lane_q, lane_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic                  rnw_q, rnw_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;
    logic [BUS_WIDTH-1:0]  bus_out_q, bus_out_d;
    logic [SELW-1:0]       byte_sel_q, byte_sel_d;
    logic                  bus_oe_q, bus_oe_d;
    logic                  memen_n_q, memen_n_d;
    logic                  we_n_q, we_n_d;
    logic                  dbin_q, dbin_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ws_met;
    logic                  in_cycle_d;

    // Position of a lane's least-significant vector bit.
    function automatic logic [IDXW-1:0] lane_base(input logic [SELW-1:0] l);
        logic [SELW-1:0] rev;
        rev = SELW'(LANES - 1) - l;
        return IDXW'(rev) * IDXW'(BUS_WIDTH);
    endfunction

    // The counter starts at 0 on the first strobe clock. It therefore meets
    // the minimum strobe length once count+1 exceeds WAIT_STATES. The
    // comparison is written with +1 so it stays meaningful when
    // WAIT_STATES is 0.
    assign ws_met = (({1'b0, cnt_q} + 1'b1) > WS_MIN);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (request) begin
                    rnw_d   = rnw;
                    word_d  = data_word;
                    lane_d  = SELW'(LANES - 1);
                    error_d = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (ws_met && ready) begin
                    if (rnw_q) begin
                        rdata_d[lane_base(lane_q) +: BUS_WIDTH] = bus_in;
                    end
                    state_d = S_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    // Abort: remaining lanes of rdata stay as they were.
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (lane_q != '0) begin
                    lane_d  = lane_q - 1'b1;
                    state_d = S_ADDR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from next-state values so that they register
        // together with the state they belong to.
        in_cycle_d = (state_d == S_ADDR) || (state_d == S_STROBE) || (state_d == S_HOLD);
        memen_n_d  = !in_cycle_d;
        we_n_d     = !((state_d == S_STROBE) && !rnw_d);
        dbin_d     = in_cycle_d && rnw_d;
        bus_oe_d   = in_cycle_d && !rnw_d;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);

        bus_out_d  = bus_out_q;
        byte_sel_d = byte_sel_q;
        if (state_d == S_ADDR) begin
            byte_sel_d = lane_d;
            if (!rnw_d) begin
                bus_out_d = word_d[lane_base(lane_d) +: BUS_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            cnt_q      <= '0;
            rnw_q      <= 1'b0;
            word_q     <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            bus_out_q  <= '0;
            byte_sel_q <= '0;
            bus_oe_q   <= 1'b0;
            memen_n_q  <= 1'b1;
            we_n_q     <= 1'b1;
            dbin_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            cnt_q      <= cnt_d;
            rnw_q      <= rnw_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            bus_out_q  <= bus_out_d;
            byte_sel_q <= byte_sel_d;
            bus_oe_q   <= bus_oe_d;
            memen_n_q  <= memen_n_d;
            we_n_q     <= we_n_d;
            dbin_q     <= dbin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign memen_n  = memen_n_q;
    assign we_n     = we_n_q;
    assign dbin     = dbin_q;
    assign byte_sel = byte_sel_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: doc/mem_cycle_gen.md
Name: mem_cycle_gen

Overview:
Parametrised memory-cycle sequencer; successor to the mock write generator.
- Runs complete read or write cycles of a DATA_WIDTH word over a narrower BUS_WIDTH multiplexed data bus, one byte lane per sub-cycle, least-significant lane first.
- Adds reads, programmable wait states, a ready input for wait-state extension, a strobe timeout with error flag, and a request/done handshake.
- Sits between the CPU-side bus interface and the external memory/peripheral bus model.

Parameters:
DATA_WIDTH, 16, word width; multiple of BUS_WIDTH.
BUS_WIDTH, 8, external data bus width.
WAIT_STATES, 0, minimum extra strobe clocks per lane (0..15).
TIMEOUT, 64, maximum strobe clocks per lane before abort (must exceed WAIT_STATES+1).
Derived: LANES = DATA_WIDTH/BUS_WIDTH; SELW = max(1, clog2(LANES)).

Ports:
clk  in  1  single system clock; all logic on rising edge.
reset_n  in  1  synchronous, active-low reset.
request  in  1  start a cycle; sampled only in IDLE.
rnw  in  1  1 = read, 0 = write; latched at acceptance.
data_word  in  DATA_WIDTH  write data, TI numbering [0:DATA_WIDTH-1], bit 0 = MSB; latched at acceptance.
ready  in  1  external ready; low extends the strobe.
bus_in  in  BUS_WIDTH  read data from the bus.
bus_out  out  BUS_WIDTH  write data to the bus.
bus_oe  out  1  drive enable for bus_out.
memen_n  out  1  memory enable, active low.
we_n  out  1  write strobe, active low.
dbin  out  1  read direction/strobe, active high.
byte_sel  out  SELW  current lane index; generalises a15.
rdata  out  DATA_WIDTH  assembled read word, TI numbering.
busy  out  1  high from acceptance through DONE.
done  out  1  one-clock completion pulse.
error  out  1  timeout flag; valid with done.

Behaviour:
- Reset: the synchronous, active-low reset (reset_n low at a clock edge) forces IDLE on the next clock. Reset values: memen_n=1, we_n=1, dbin=0, bus_oe=0, bus_out=0, byte_sel=0, rdata=0, busy=0, done=0, error=0.
- Reset mid-cycle: abort immediately with the reset values above; no done pulse.
- All outputs are registered and decoded from state, lane counter and strobe counter.

States: IDLE, ADDR, STROBE, HOLD, DONE.

- IDLE:
  - request=1 at a clock edge: latch rnw and data_word, set lane=LANES-1, busy=1, clear error, enter ADDR.
  - request=0: remain in IDLE.
- ADDR (1 clk):
  - memen_n=0; byte_sel=lane.
  - Write: bus_oe=1, bus_out = lane bits [lane*BUS_WIDTH : lane*BUS_WIDTH+BUS_WIDTH-1] (TI numbering). lane LANES-1 is the least-significant byte.
  - Read: dbin=1, bus_oe=0.
  - Clear the strobe counter; enter STROBE.
- STROBE:
  - we_n=0 for writes; dbin stays 1 for reads.
  - The strobe counter increments each clock.
  - Exit when counter >= WAIT_STATES and ready=1. On a read, capture bus_in into the rdata lane at that edge. Enter HOLD.
  - Timeout: counter reaches TIMEOUT-1 with ready=0 → set error, drop all strobes, enter DONE. Lanes already captured are kept; the remaining lanes are unchanged.
- HOLD (1 clk):
  - we_n=1; memen_n, dbin, bus_oe and bus_out are held.
  - lane>0: decrement lane, enter ADDR. memen_n stays low; there is no gap between lanes.
  - lane=0: enter DONE.
- DONE (1 clk):
  - done=1; memen_n=1, dbin=0, bus_oe=0; busy stays 1 this clock.
  - error is valid this clock. rdata is valid and held until the next acceptance.
  - Next state is IDLE.
- request held high: a new cycle is accepted in the IDLE clock after DONE. The minimum request-to-request spacing is the full cycle plus 1 idle clock.
- request during busy: ignored; no queuing.
- Latency with ready tied high: each lane takes WAIT_STATES+3 clocks. Total from acceptance edge to the done pulse is LANES*(WAIT_STATES+3)+1 clocks.
- ready changes are observed only in STROBE.

Test Plan:
1. Defaults, write 0x1234 with ready=1:
   - byte_sel 1 then 0; bus_out 0x34 then 0x12.
   - we_n low 1 clk per lane; memen_n low 6 continuous clocks.
   - done 7 clocks after acceptance; error=0.
2. Read with bus_in 0xCD in lane 1 and 0xAB in lane 0:
   - rdata=0xABCD at done; dbin high 6 clocks.
   - bus_oe never asserted; we_n never low.
3. WAIT_STATES=2, write with ready=0 for 3 extra clocks in lane 1:
   - lane-1 strobe lasts 6 clocks; lane-0 strobe lasts 3.
   - done at 1+6+1 + 1+3+1 + 1 = 14 clocks.
4. TIMEOUT=8, read with ready held low:
   - strobe ends after 8 clocks; done=1 and error=1 together.
   - memen_n high at DONE; next request clears error.
5. reset_n low during STROBE of lane 0:
   - all outputs at reset values next clock; no done pulse.
   - subsequent request runs normally.
6. DATA_WIDTH=32, request held high, write 0xDEADBEEF:
   - byte_sel 3,2,1,0; bus_out 0xEF,0xBE,0xAD,0xDE.
   - second cycle accepted the clock after DONE; request during busy ignored.
